dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter and sequencer in front of the byte-addressed, big-endian data memory (four bytes per 32-bit word, combinational read, write on clock edge). Requester 0 is the core load/store path. Requester 1 is the program loader/debug port. The block accepts one word request at a time, using round-robin grant between the two requesters. It screens each request for alignment and range, and drives the memory for exactly one cycle per accepted request. Results come back as a registered `done` pulse, with read data when the request was a read.

## Interface
Parameters:
- `MEM_BYTES`, 1024: memory size in bytes. A word access is legal only when `addr + 3 < MEM_BYTES`.

Ports (clock and reset first):
- `clk`: input, 1 bit, the single clock.
- `reset`: input, 1 bit, **asynchronous, active-high**.
- `rN_valid`: input, 1 bit, N ∈ {0,1}. Request present.
- `rN_write`: input, 1 bit. 1 = store, 0 = load.
- `rN_addr`: input, 32 bits. Byte address.
- `rN_wdata`: input, 32 bits. Store data.
- `rN_ready`: output, 1 bit. Request accepted this cycle.
- `rN_done`: output, 1 bit. One-cycle completion pulse.
- `rN_err`: output, 1 bit. Qualifies `done`: the request was rejected.
- `rN_rdata`: output, 32 bits. Load result, valid while `rN_done` is high.
- `mem_write`: output, 1 bit. Memory write strobe.
- `mem_address`: output, 32 bits. Memory byte address.
- `mem_write_data`: output, 32 bits. Memory write data.
- `mem_read_data`: input, 32 bits. Memory combinational read data.
- `busy`: output, 1 bit. High when the state is not IDLE.

## Operation
- FSM states: IDLE, ACCESS.
- **IDLE, grant selection:**
  - If exactly one `rN_valid` is high, grant it.
  - If both are high, grant the requester that is not `last_grant`.
  - `rN_ready` is combinational and asserted only in IDLE, only for the granted requester.
- **IDLE, on grant:**
  - Latch `addr`, `write`, `wdata` and the grant id.
  - Set `last_grant` to the grant id.
  - Compute `bad = (addr[1:0] != 0) || (addr > MEM_BYTES - 4)` and latch it.
  - Move to ACCESS.
- **ACCESS:**
  - `mem_address` = latched addr; `mem_write_data` = latched wdata.
  - `mem_write` = latched write && !bad.
  - Capture `mem_read_data` into a 32-bit result register when the request is a read and !bad.
  - Return to IDLE unconditionally.
- **Completion cycle** (the cycle after ACCESS, state is IDLE):
  - The granted requester sees `rN_done=1` for one cycle.
  - `rN_err = bad`.
  - `rN_rdata` = captured word for a good read. It is 0 for writes and errors.
  - The other requester's `done`/`err` stay 0.
- Errored requests never assert `mem_write`; memory contents are unchanged.
- `mem_address`/`mem_write_data` keep their last latched values outside ACCESS. `mem_write` is 0 outside ACCESS.
- Requesters hold `valid` and all request fields stable until `ready`. Behaviour when `valid` is dropped early is undefined.
- `last_grant` toggles only on a grant. With both requesters continuously valid, grants alternate 0,1,0,1…

## Timing
- **Reset values:**
  - state = IDLE, `last_grant` = 1, so requester 0 wins the first tie.
  - All `ready`/`done`/`err`/`mem_write`/`busy` = 0.
  - `rN_rdata` = 0, `mem_address` = 0, `mem_write_data` = 0.
- **Latency:** accept at cycle T, memory access at T+1, `done` at T+2.
- **Throughput:** one request per 2 cycles. A new accept may occur in the same cycle as the previous `done`.
- **Simultaneous `done` and `ready`:**
  - Allowed, even when both go to the same requester.
  - The requester must treat `done` as belonging to the earlier request.
- **Write timing:** data is in memory at the clock edge ending ACCESS. A read accepted at T+2 of that write returns the new data.
- **Reset mid-operation:**
  - Reset asserted during ACCESS forces `mem_write` to 0 immediately (asynchronous).
  - The transaction is dropped and no `done` is produced.
  - Memory may or may not have captured the write, depending on edge alignment. Software must not rely on either outcome.
- **Single requester** valid every cycle: accepted at T, T+2, T+4, …

## Test plan
1. Reset, then r0 writes 0x11223344 to address 8. Required:
   - `r0_ready` at T.
   - `mem_write=1`, `mem_address=8` at T+1.
   - `r0_done=1`, `r0_err=0` at T+2.
   - Then r0 reads address 8: `r0_rdata=0x11223344` with `done`.
2. Both valid from reset, r0 reads address 0 and r1 reads address 4. Required:
   - r0 is granted first and r1 two cycles later.
   - Each `done` pulses only on its own port.
   - Hold both valid for 6 grants and check the grant order 0,1,0,1,0,1.
3. r1 writes to address 6 (misaligned). Required:
   - `mem_write` stays 0 throughout.
   - `r1_done=1`, `r1_err=1`, `r1_rdata=0`.
   - A follow-up read of address 4 returns its prior value.
4. With `MEM_BYTES=1024`:
   - r0 reads address 1020: `err=0`.
   - r0 reads address 1024: `err=1`, no memory access.
   - r0 reads address 0xFFFFFFFC: `err=1`.
5. r0 issues back-to-back requests, write 0xDEADBEEF to address 12 then read address 12. Required:
   - The second `ready` coincides with the first `done`.
   - The read returns 0xDEADBEEF.
6. Assert `reset` in the middle of the ACCESS cycle of a write. Required:
   - `mem_write` drops to 0 before the next edge.
   - No `done`.
   - All outputs at their reset values.
   - `busy=0`.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-requester front end that screens word requests
// and drives a combinational-read data memory for one cycle per accepted request.
module dmem_arbiter #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        r0_valid,
  input  logic        r0_write,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  output logic        r0_ready,
  output logic        r0_done,
  output logic        r0_err,
  output logic [31:0] r0_rdata,
  input  logic        r1_valid,
  input  logic        r1_write,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r1_ready,
  output logic        r1_done,
  output logic        r1_err,
  output logic [31:0] r1_rdata,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        busy
);
  typedef enum logic {IDLE, ACCESS} state_t;
  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);
  state_t state, state_next;
  logic last_grant, grant, grant_id, req_write, req_bad;
  logic [31:0] req_addr, req_wdata;
  logic write_q, id_q, bad_q, done0_q, done1_q, err_q;
  logic [31:0] addr_q, wdata_q, res_q;
  always_comb begin
    grant_id = (r0_valid && r1_valid) ? !last_grant : r1_valid;
    grant = state == IDLE && (r0_valid || r1_valid);
    req_addr = grant_id ? r1_addr : r0_addr;
    req_wdata = grant_id ? r1_wdata : r0_wdata;
    req_write = grant_id ? r1_write : r0_write;
    req_bad = req_addr[1:0] != 2'b00 || req_addr > LAST_WORD;
    state_next = grant ? ACCESS : IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_next;
  // last_grant resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      addr_q <= 32'h0;
      wdata_q <= 32'h0;
      res_q <= 32'h0;
      write_q <= 1'b0;
      id_q <= 1'b0;
      bad_q <= 1'b0;
      err_q <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      done0_q <= state == ACCESS && !id_q;
      done1_q <= state == ACCESS && id_q;
      if (state == ACCESS) begin
        err_q <= bad_q;
        res_q <= (!write_q && !bad_q) ? mem_read_data : 32'h0;
      end
      if (grant) begin
        addr_q <= req_addr;
        wdata_q <= req_wdata;
        write_q <= req_write;
        bad_q <= req_bad;
        id_q <= grant_id;
        last_grant <= grant_id;
      end
    end
  end
  assign r0_ready = grant && !grant_id;
  assign r1_ready = grant && grant_id;
  assign r0_done = done0_q;
  assign r1_done = done1_q;
  assign r0_err = done0_q && err_q;
  assign r1_err = done1_q && err_q;
  assign r0_rdata = done0_q ? res_q : 32'h0;
  assign r1_rdata = done1_q ? res_q : 32'h0;
  assign mem_write = state == ACCESS && write_q && !bad_q;
  assign mem_address = addr_q;
  assign mem_write_data = wdata_q;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a
// byte-array reference memory and the round-robin / screening rules.
module tb_dmem_arbiter;
  localparam int MB = 1024;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic r0_valid = 0, r0_write = 0, r1_valid = 0, r1_write = 0;
  logic [31:0] r0_addr = 0, r0_wdata = 0, r1_addr = 0, r1_wdata = 0;
  logic r0_ready, r0_done, r0_err, r1_ready, r1_done, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic mem_write, busy;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic [7:0] mem [MB];
  logic [7:0] ref_mem [MB];
  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_BYTES(MB)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ready(r0_ready), .r0_done(r0_done), .r0_err(r0_err), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ready(r1_ready), .r1_done(r1_done), .r1_err(r1_err), .r1_rdata(r1_rdata),
    .mem_write(mem_write), .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .busy(busy)
  );

  // big-endian memory stand-in: combinational read, write on the clock edge
  assign mem_read_data = (mem_address <= 32'(MB - 4)) ?
    {mem[mem_address[9:0]], mem[mem_address[9:0] + 10'd1],
     mem[mem_address[9:0] + 10'd2], mem[mem_address[9:0] + 10'd3]} : 32'h0;

  initial begin
    #1;
    for (int i = 0; i < MB; i++) mem[i] = ref_mem[i];
    forever begin
      @(posedge clk);
      if (mem_write && mem_address <= 32'(MB - 4))
        for (int k = 0; k < 4; k++) mem[int'(mem_address) + k] = mem_write_data[31 - 8 * k -: 8];
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_bad(logic [31:0] a);
    return (a % 4) != 0 || longint'(a) + 3 >= MB;
  endfunction

  function automatic logic [31:0] ref_word(logic [31:0] a);
    int i = int'(a);
    return {ref_mem[i], ref_mem[i + 1], ref_mem[i + 2], ref_mem[i + 3]};
  endfunction

  function automatic logic rdy(int p);
    return p == 0 ? r0_ready : r1_ready;
  endfunction

  task automatic set_req(int p, logic v, logic w, logic [31:0] a, logic [31:0] d);
    if (p == 0) begin r0_valid = v; r0_write = w; r0_addr = a; r0_wdata = d; end
    else begin r1_valid = v; r1_write = w; r1_addr = a; r1_wdata = d; end
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, ".r0_ready"}, r0_ready, 0);
    chk({tag, ".r1_ready"}, r1_ready, 0);
    chk({tag, ".r0_done"}, r0_done, 0);
    chk({tag, ".r1_done"}, r1_done, 0);
    chk({tag, ".r0_err"}, r0_err, 0);
    chk({tag, ".r1_err"}, r1_err, 0);
    chk({tag, ".r0_rdata"}, r0_rdata, 0);
    chk({tag, ".r1_rdata"}, r1_rdata, 0);
    chk({tag, ".mem_write"}, mem_write, 0);
    chk({tag, ".mem_address"}, mem_address, 0);
    chk({tag, ".mem_write_data"}, mem_write_data, 0);
    chk({tag, ".busy"}, busy, 0);
  endtask

  // one isolated request: accept at T, access at T+1, done at T+2
  task automatic xact(string tag, int p, logic w, logic [31:0] a, logic [31:0] d);
    logic b;
    logic [31:0] er;
    int n = 0;
    b = ref_bad(a);
    er = (w || b) ? 32'h0 : ref_word(a);
    set_req(p, 1, w, a, d);
    @(negedge clk);
    while (!rdy(p) && n < 8) begin @(posedge clk); #1; @(negedge clk); n++; end
    chk({tag, ".ready"}, rdy(p), 1);
    @(posedge clk); #1;
    set_req(p, 0, 0, 0, 0);
    @(negedge clk);
    chk({tag, ".mem_write"}, mem_write, w && !b);
    chk({tag, ".mem_address"}, mem_address, a);
    chk({tag, ".busy"}, busy, 1);
    if (w && !b) begin
      chk({tag, ".mem_write_data"}, mem_write_data, d);
      for (int k = 0; k < 4; k++) ref_mem[int'(a) + k] = d[31 - 8 * k -: 8];
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, ".done"}, p == 0 ? r0_done : r1_done, 1);
    chk({tag, ".err"}, p == 0 ? r0_err : r1_err, b);
    chk({tag, ".rdata"}, p == 0 ? r0_rdata : r1_rdata, er);
    chk({tag, ".other_done"}, p == 0 ? r1_done : r0_done, 0);
    chk({tag, ".other_err"}, p == 0 ? r1_err : r0_err, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int prev;
    int g;
    logic [31:0] a;
    for (int i = 0; i < MB; i++) ref_mem[i] = 8'($urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outs("reset");
    @(posedge clk); #1;
    reset = 0;

    xact("t1_write8", 0, 1, 32'd8, 32'h11223344);
    xact("t1_read8", 0, 0, 32'd8, 32'h0);
    chk("t1_model_word8", ref_word(32'd8), 32'h11223344);

    reset = 1;
    set_req(0, 1, 0, 32'd0, 32'h0);
    set_req(1, 1, 0, 32'd4, 32'h0);
    @(posedge clk); #1;
    reset = 0;
    prev = -1;
    for (int k = 0; k < 6; k++) begin
      g = k % 2;
      @(negedge clk);
      chk("t2_r0_ready", r0_ready, g == 0);
      chk("t2_r1_ready", r1_ready, g == 1);
      if (prev >= 0) begin
        chk("t2_r0_done", r0_done, prev == 0);
        chk("t2_r1_done", r1_done, prev == 1);
        chk("t2_rdata", prev == 0 ? r0_rdata : r1_rdata, ref_word(prev == 0 ? 32'd0 : 32'd4));
      end
      prev = g;
      @(posedge clk); #1;
      @(negedge clk);
      chk("t2_access_no_ready", {r0_ready, r1_ready}, 0);
      @(posedge clk); #1;
      if (k == 5) begin set_req(0, 0, 0, 0, 0); set_req(1, 0, 0, 0, 0); end
    end
    @(negedge clk);
    chk("t2_last_r1_done", r1_done, 1);
    chk("t2_last_r0_done", r0_done, 0);
    chk("t2_last_rdata", r1_rdata, ref_word(32'd4));
    @(posedge clk); #1;

    xact("t3_misaligned_write", 1, 1, 32'd6, 32'hCAFEF00D);
    xact("t3_read4", 1, 0, 32'd4, 32'h0);

    xact("t4_read1020", 0, 0, 32'd1020, 32'h0);
    xact("t4_read1024", 0, 0, 32'd1024, 32'h0);
    xact("t4_readFFFFFFFC", 0, 0, 32'hFFFFFFFC, 32'h0);

    set_req(0, 1, 1, 32'd12, 32'hDEADBEEF);
    @(negedge clk);
    chk("t5_ready1", r0_ready, 1);
    @(posedge clk); #1;
    set_req(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t5_mem_write", mem_write, 1);
    for (int k = 0; k < 4; k++) ref_mem[12 + k] = 8'(32'hDEADBEEF >> (24 - 8 * k));
    @(posedge clk); #1;
    set_req(0, 1, 0, 32'd12, 32'h0);
    @(negedge clk);
    chk("t5_done1", r0_done, 1);
    chk("t5_ready2_with_done1", r0_ready, 1);
    chk("t5_done1_rdata", r0_rdata, 0);
    @(posedge clk); #1;
    set_req(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t5_access2_mem_write", mem_write, 0);
    chk("t5_access2_addr", mem_address, 32'd12);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_done2", r0_done, 1);
    chk("t5_rdata2", r0_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;

    for (int k = 0; k < 40; k++) begin
      int sel = int'($urandom % 8);
      a = sel < 5 ? 4 * ($urandom % 256) :
          sel == 5 ? 4 * ($urandom % 255) + 1 + ($urandom % 3) :
          sel == 6 ? 32'd1024 + 4 * ($urandom % 100) : 32'hFFFFFFFC;
      xact("rand", int'($urandom % 2), 1'($urandom), a, $urandom);
    end

    set_req(0, 1, 1, 32'd16, 32'h5A5A5A5A);
    @(negedge clk);
    chk("t6_ready", r0_ready, 1);
    @(posedge clk); #1;
    set_req(0, 0, 0, 0, 0);
    #2;
    chk("t6_mem_write_before", mem_write, 1);
    reset = 1;
    #1;
    chk("t6_mem_write_dropped", mem_write, 0);
    @(negedge clk);
    chk_reset_outs("t6");
    @(posedge clk); #1;
    reset = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_no_done", {r0_done, r1_done}, 0);
      chk("t6_idle", busy, 0);
    end

    $display("test done: total=%0d bad=%0d", total, fails);
    $finish;
  end
endmodule
